// File: rtl/ic_tester_pkg.sv
// ic_tester_pkg: shared gate_sel codes, FSM state encoding and settle default.
package ic_tester_pkg;
  localparam logic [2:0] GATE_AND = 3'd0;
  localparam logic [2:0] GATE_OR = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR = 3'd3;
  localparam logic [2:0] GATE_XOR = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;
  localparam logic [2:0] GATE_SEL_MAX = 3'd5;
  localparam int ONE_SECOND_CYCLES = 50000000;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
endpackage

// File: rtl/gate_golden_model.sv
// gate_golden_model: combinational reference gate selected by sel_i.
module gate_golden_model
  import ic_tester_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0] pattern_i,
  input  logic [2:0]        sel_i,
  output logic              expected_o
);
  always_comb
    expected_o = sel_i == GATE_AND  ?  &pattern_i :
                 sel_i == GATE_OR   ?  |pattern_i :
                 sel_i == GATE_NAND ? ~&pattern_i :
                 sel_i == GATE_NOR  ? ~|pattern_i :
                 sel_i == GATE_XOR  ?  ^pattern_i :
                 sel_i == GATE_XNOR ? ~^pattern_i : 1'b0;
endmodule

// File: rtl/gate_array_checker.sv
// gate_array_checker: exhaustive sweep of NUM_GATES gates against a golden function.
// Optional first-failure capture ports when FIRST_FAIL_CAPTURE_EN is defined.
module gate_array_checker
  import ic_tester_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int NUM_GATES = 4,
  parameter int SETTLE_CYCLES = ONE_SECOND_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           gate_sel,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic [NUM_IN-1:0]    gate_in,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [NUM_GATES-1:0] pass_vec,
  output logic [NUM_GATES-1:0] fail_vec,
  output logic                 pass,
  output logic                 fail
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [NUM_IN-1:0]    first_fail_pat,
  output logic [NUM_GATES-1:0] first_fail_mask,
  output logic                 first_fail_valid
`endif
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  state_t               state_q;
  logic [2:0]           sel_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_IN-1:0]    gate_in_q;
  logic [NUM_GATES-1:0] mismatch_q, mismatch_d, inst_mm;
  logic [NUM_GATES-1:0] pass_vec_q, fail_vec_q;
  logic                 busy_q, done_q, cfg_err_q, pass_q, fail_q, expected;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [NUM_IN-1:0]    ff_pat_q;
  logic [NUM_GATES-1:0] ff_mask_q;
  logic                 ff_valid_q;
  assign first_fail_pat = ff_pat_q;
  assign first_fail_mask = ff_mask_q;
  assign first_fail_valid = ff_valid_q;
`endif
  gate_golden_model #(.NUM_IN(NUM_IN)) u_golden (
    .pattern_i (gate_in_q),
    .sel_i     (sel_q),
    .expected_o(expected)
  );
  // mismatch_d already includes the current sample so the last pattern counts
  always_comb begin
    inst_mm = gate_out ^ {NUM_GATES{expected}};
    mismatch_d = mismatch_q | inst_mm;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      gate_in_q <= '0;
      mismatch_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
      pass_vec_q <= '0;
      fail_vec_q <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_pat_q <= '0;
      ff_mask_q <= '0;
      ff_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q <= 1'b0;
        gate_in_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            if (gate_sel <= GATE_SEL_MAX) begin
              sel_q <= gate_sel;
              gate_in_q <= '0;
              cnt_q <= '0;
              mismatch_q <= '0;
              busy_q <= 1'b1;
              state_q <= SETTLE;
`ifdef FIRST_FAIL_CAPTURE_EN
              ff_pat_q <= '0;
              ff_mask_q <= '0;
              ff_valid_q <= 1'b0;
`endif
            end else cfg_err_q <= 1'b1;
          end
          SETTLE: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= SAMPLE;
          end
          SAMPLE: begin
            mismatch_q <= mismatch_d;
`ifdef FIRST_FAIL_CAPTURE_EN
            if (!ff_valid_q && |inst_mm) begin
              ff_pat_q <= gate_in_q;
              ff_mask_q <= inst_mm;
              ff_valid_q <= 1'b1;
            end
`endif
            if (!(&gate_in_q)) begin
              gate_in_q <= gate_in_q + 1'b1;
              cnt_q <= '0;
              state_q <= SETTLE;
            end else begin
              pass_vec_q <= ~mismatch_d;
              fail_vec_q <= mismatch_d;
              pass_q <= ~|mismatch_d;
              fail_q <= |mismatch_d;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              gate_in_q <= '0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign gate_in = gate_in_q;
  assign busy = busy_q;
  assign done = done_q;
  assign cfg_err = cfg_err_q;
  assign pass_vec = pass_vec_q;
  assign fail_vec = fail_vec_q;
  assign pass = pass_q;
  assign fail = fail_q;
endmodule
